// File: rtl/fwd_pkg.sv
// Shared definitions for the operand-forwarding scoreboard.
//   - Default values for the scoreboard parameters.
//   - tag_t  : what an in-flight instruction contributes to forwarding
//              decisions (write enable, destination, forwardable slot).
//   - slot_t : one tracked pipeline slot, i.e. a tag plus its valid bit.
// Tag fields use fixed container widths so the struct can be shared by
// modules with different parameterisations. REG_AW and the latency width
// must not exceed TAG_RD_W and TAG_LAT_W respectively.
package fwd_pkg;

  localparam int REG_AW_DEF = 5;
  localparam int STAGES_DEF = 3;
  localparam int NSRC_DEF   = 2;
  localparam int CNT_W_DEF  = 16;

  localparam int TAG_RD_W   = 8;
  localparam int TAG_LAT_W  = 8;

  typedef struct packed {
    logic                 we;
    logic [TAG_RD_W-1:0]  rd;
    logic [TAG_LAT_W-1:0] lat;
  } tag_t;

  typedef struct packed {
    logic valid;
    tag_t tag;
  } slot_t;

endpackage

// File: rtl/fwd_src_match.sv
// Per-operand forwarding lookup.
// Scans the tracked slots for the youngest (lowest-numbered) instruction
// that writes the requested source register and reports where to take the
// operand from and whether that value is forwardable yet.
// Ports:
//   slots     in  STAGES packed slot_t  tracked slot state, index 1 = EX
//   src       in  REG_AW               source register address
//   sel       out SELW                 0 = register file, s = slot s
//   not_ready out 1                    youngest match has not produced yet
module fwd_src_match
  import fwd_pkg::*;
#(
  parameter  int REG_AW = REG_AW_DEF,
  parameter  int STAGES = STAGES_DEF,
  localparam int SELW   = $clog2(STAGES + 1)
) (
  input  slot_t [STAGES:1]   slots,
  input  logic  [REG_AW-1:0] src,
  output logic  [SELW-1:0]   sel,
  output logic               not_ready
);

  logic found;

  // Only the youngest match matters: an older, already-ready producer holds
  // a stale value once a younger writer of the same register is in flight.
  always_comb begin
    sel       = '0;
    not_ready = 1'b0;
    found     = 1'b0;
    for (int s = 1; s <= STAGES; s++) begin
      if (!found && slots[s].valid && slots[s].tag.we &&
          (slots[s].tag.rd == TAG_RD_W'(src)) && (src != '0)) begin
        found     = 1'b1;
        sel       = SELW'(s);
        not_ready = (TAG_LAT_W'(s) < slots[s].tag.lat);
      end
    end
  end

endmodule

// File: rtl/fwd_scoreboard.sv
// Operand-forwarding scoreboard for an in-order pipeline.
// Tracks the destination of every instruction between EX (slot 1) and WB
// (slot STAGES), selects a forwarding source for each decode-stage operand
// and raises stall while a needed result is not yet forwardable.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   issue_valid  decode instruction offered for issue
//   issue_we     issuing instruction writes a register
//   issue_rd     its destination register
//   issue_lat    slot at which its result becomes forwardable
//   flush        kill the decode instruction
//   src_addr     packed source registers, operand i at [i*REG_AW +: REG_AW]
//   src_used     operand i is actually read
//   fwd_sel      packed per-operand source select, operand i at [i*SELW +: SELW]
//   stall        hold decode/fetch, bubble into slot 1
//   stall_cnt    saturating count of stall cycles
module fwd_scoreboard
  import fwd_pkg::*;
#(
  parameter  int REG_AW = REG_AW_DEF,
  parameter  int STAGES = STAGES_DEF,
  parameter  int NSRC   = NSRC_DEF,
  parameter  int CNT_W  = CNT_W_DEF,
  localparam int SELW   = $clog2(STAGES + 1),
  localparam int LATW   = $clog2(STAGES + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   issue_valid,
  input  logic                   issue_we,
  input  logic [REG_AW-1:0]      issue_rd,
  input  logic [LATW-1:0]        issue_lat,
  input  logic                   flush,
  input  logic [NSRC*REG_AW-1:0] src_addr,
  input  logic [NSRC-1:0]        src_used,
  output logic [NSRC*SELW-1:0]   fwd_sel,
  output logic                   stall,
  output logic [CNT_W-1:0]       stall_cnt
);

  // A zero latency still means "available from EX"; anything past the last
  // tracked slot would never be reached, so it is pinned to the last slot.
  function automatic logic [TAG_LAT_W-1:0] clamp_lat(input logic [LATW-1:0] lat);
    logic [TAG_LAT_W-1:0] r;
    if (lat == '0)
      r = TAG_LAT_W'(1);
    else if (int'(lat) > STAGES)
      r = TAG_LAT_W'(STAGES);
    else
      r = TAG_LAT_W'(lat);
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  logic [STAGES:1]  vld_p;
  tag_t [STAGES:1]  tag_p;
  slot_t [STAGES:1] slot_view;
  logic [NSRC-1:0]  not_ready;

  // Decode -> slot 1 capture; slots s -> s+1 shift, last slot retires.
  // Only the valid bits and the counter are reset; tags are qualified by
  // their valid bit and need no reset value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p     <= '0;
      stall_cnt <= '0;
    end else begin
      vld_p[1] <= issue_valid & ~stall & ~flush;
      for (int s = 2; s <= STAGES; s++)
        vld_p[s] <= vld_p[s-1];
      if (stall)
        stall_cnt <= sat_inc(stall_cnt);
    end
  end

  always_ff @(posedge clk) begin
    tag_p[1] <= '{we: issue_we, rd: TAG_RD_W'(issue_rd), lat: clamp_lat(issue_lat)};
    for (int s = 2; s <= STAGES; s++)
      tag_p[s] <= tag_p[s-1];
  end

  always_comb begin
    slot_view = '0;
    for (int s = 1; s <= STAGES; s++) begin
      slot_view[s].valid = vld_p[s];
      slot_view[s].tag   = tag_p[s];
    end
  end

  // Decode-stage lookup, one matcher per source operand.
  for (genvar i = 0; i < NSRC; i++) begin : g_src
    fwd_src_match #(
      .REG_AW (REG_AW),
      .STAGES (STAGES)
    ) u_match (
      .slots     (slot_view),
      .src       (src_addr[i*REG_AW +: REG_AW]),
      .sel       (fwd_sel[i*SELW +: SELW]),
      .not_ready (not_ready[i])
    );
  end

  // A flushed decode instruction is discarded, so it can never wait.
  assign stall = ~flush & (|(not_ready & src_used));

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Bench for fwd_scoreboard (STAGES=3, NSRC=2). A second instance with a
// 4-bit stall counter shares all inputs so counter saturation is reachable.
module tb_fwd_scoreboard;

  localparam int RAW = 5;
  localparam int ST  = 3;
  localparam int NS  = 2;
  localparam int SW  = 2;
  localparam int LW  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n       = 1'b0;
  logic              issue_valid = 1'b0;
  logic              issue_we    = 1'b0;
  logic [RAW-1:0]    issue_rd    = '0;
  logic [LW-1:0]     issue_lat   = '0;
  logic              flush       = 1'b0;
  logic [NS*RAW-1:0] src_addr    = '0;
  logic [NS-1:0]     src_used    = '0;
  logic [NS*SW-1:0]  fwd_sel, fwd_sel_s;
  logic              stall, stall_s;
  logic [15:0]       stall_cnt;
  logic [3:0]        stall_cnt_s;

  fwd_scoreboard #(.REG_AW(RAW), .STAGES(ST), .NSRC(NS), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_we(issue_we),
    .issue_rd(issue_rd), .issue_lat(issue_lat), .flush(flush),
    .src_addr(src_addr), .src_used(src_used), .fwd_sel(fwd_sel),
    .stall(stall), .stall_cnt(stall_cnt)
  );

  fwd_scoreboard #(.REG_AW(RAW), .STAGES(ST), .NSRC(NS), .CNT_W(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_we(issue_we),
    .issue_rd(issue_rd), .issue_lat(issue_lat), .flush(flush),
    .src_addr(src_addr), .src_used(src_used), .fwd_sel(fwd_sel_s),
    .stall(stall_s), .stall_cnt(stall_cnt_s)
  );

  // Reference model: list of in-flight instructions with their age in
  // cycles since issue (age 1 = EX). Retired once older than ST.
  typedef struct { logic we; int rd; int lat; int age; } inst_t;
  typedef struct { logic [NS*SW-1:0] sel; logic stall; logic [15:0] cnt; logic [3:0] cnt_s; } exp_t;

  inst_t pipe_q[$];
  exp_t  exp_q[$];
  int    m_stalls   = 0;
  logic  last_stall = 1'b0;
  int    n_chk      = 0;
  int    n_pass     = 0;

  function automatic int eff_lat(input int lat);
    if (lat == 0) return 1;
    if (lat > ST) return ST;
    return lat;
  endfunction

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
  endfunction

  // One decode cycle: drive inputs just after the edge, predict outputs.
  task automatic cycle(input logic rn, input logic iv, input logic iwe, input int ird,
                       input int ilat, input logic fl, input int s0, input int s1,
                       input logic [1:0] used);
    exp_t  e;
    inst_t nq[$];
    inst_t ni;
    logic  any_nr;
    @(posedge clk);
    #1;
    rst_n       = rn;
    issue_valid = iv;
    issue_we    = iwe;
    issue_rd    = RAW'(ird);
    issue_lat   = LW'(ilat);
    flush       = fl;
    src_addr    = {RAW'(s1), RAW'(s0)};
    src_used    = used;
    e.sel = '0;
    if (!rn) begin
      pipe_q.delete();
      m_stalls   = 0;
      e.stall    = 1'b0;
      e.cnt      = '0;
      e.cnt_s    = '0;
      exp_q.push_back(e);
      last_stall = 1'b0;
      return;
    end
    any_nr = 1'b0;
    for (int i = 0; i < NS; i++) begin
      int   src;
      int   best;
      logic nr;
      src  = (i == 0) ? s0 : s1;
      best = 0;
      nr   = 1'b0;
      foreach (pipe_q[k])
        if (pipe_q[k].we && pipe_q[k].rd == src && src != 0 &&
            (best == 0 || pipe_q[k].age < best)) begin
          best = pipe_q[k].age;
          nr   = (best < eff_lat(pipe_q[k].lat));
        end
      e.sel[i*SW +: SW] = SW'(best);
      if (used[i] && nr) any_nr = 1'b1;
    end
    e.stall = any_nr && !fl;
    e.cnt   = 16'((m_stalls > 65535) ? 65535 : m_stalls);
    e.cnt_s = 4'((m_stalls > 15) ? 15 : m_stalls);
    exp_q.push_back(e);
    foreach (pipe_q[k]) begin
      ni = pipe_q[k];
      ni.age++;
      if (ni.age <= ST) nq.push_back(ni);
    end
    if (iv && !e.stall && !fl) begin
      ni.we = iwe; ni.rd = ird; ni.lat = ilat; ni.age = 1;
      nq.push_back(ni);
    end
    pipe_q = nq;
    if (e.stall) m_stalls++;
    last_stall = e.stall;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b1, 1'b0, 1'b0, 0, 1, 1'b0, 0, 0, 2'b00);
  endtask

  // Monitor: compares the DUT against the oldest prediction each cycle.
  always @(negedge clk) begin : mon
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("fwd_sel",     32'(fwd_sel),     32'(e.sel));
      check("stall",       32'(stall),       32'(e.stall));
      check("stall_cnt",   32'(stall_cnt),   32'(e.cnt));
      check("fwd_sel_s",   32'(fwd_sel_s),   32'(e.sel));
      check("stall_s",     32'(stall_s),     32'(e.stall));
      check("stall_cnt_s", 32'(stall_cnt_s), 32'(e.cnt_s));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic rn, iv, iwe, fl;
    int   ird, ilat, s0, s1;
    logic [1:0] used;

    // Reset with random-looking inputs applied.
    cycle(1'b0, 1'b1, 1'b1, 5, 1, 1'b0, 5, 5, 2'b11);
    cycle(1'b0, 1'b1, 1'b1, 7, 3, 1'b0, 7, 0, 2'b11);
    idle(1);

    // ALU chain: forward from slot 1 then slot 2.
    cycle(1'b1, 1'b1, 1'b1, 5, 1, 1'b0, 0, 0, 2'b00);
    cycle(1'b1, 1'b0, 1'b0, 0, 1, 1'b0, 5, 0, 2'b01);
    cycle(1'b1, 1'b0, 1'b0, 0, 1, 1'b0, 5, 0, 2'b01);
    idle(3);

    // Load-use: one stall, then forward from slot 2.
    cycle(1'b1, 1'b1, 1'b1, 7, 2, 1'b0, 0, 0, 2'b00);
    repeat (2) cycle(1'b1, 1'b1, 1'b1, 10, 1, 1'b0, 0, 7, 2'b10);
    idle(3);

    // Priority: youngest writer wins.
    cycle(1'b1, 1'b1, 1'b1, 3, 1, 1'b0, 0, 0, 2'b00);
    cycle(1'b1, 1'b1, 1'b1, 3, 1, 1'b0, 0, 0, 2'b00);
    cycle(1'b1, 1'b0, 1'b0, 0, 1, 1'b0, 3, 0, 2'b01);
    idle(3);
    cycle(1'b1, 1'b1, 1'b1, 3, 1, 1'b0, 0, 0, 2'b00);
    cycle(1'b1, 1'b1, 1'b1, 3, 3, 1'b0, 0, 0, 2'b00);
    repeat (3) cycle(1'b1, 1'b1, 1'b1, 8, 1, 1'b0, 3, 0, 2'b01);
    idle(3);

    // r0 is never forwarded; unused unready operand does not stall.
    cycle(1'b1, 1'b1, 1'b1, 0, 1, 1'b0, 0, 0, 2'b00);
    cycle(1'b1, 1'b0, 1'b0, 0, 1, 1'b0, 0, 0, 2'b11);
    cycle(1'b1, 1'b1, 1'b1, 4, 3, 1'b0, 0, 0, 2'b00);
    cycle(1'b1, 1'b0, 1'b0, 0, 1, 1'b0, 4, 4, 2'b00);
    idle(3);

    // Flushed issue never enters; flush also suppresses a pending stall.
    cycle(1'b1, 1'b1, 1'b1, 9, 1, 1'b1, 0, 0, 2'b00);
    cycle(1'b1, 1'b0, 1'b0, 0, 1, 1'b0, 9, 0, 2'b01);
    cycle(1'b1, 1'b1, 1'b1, 6, 3, 1'b0, 0, 0, 2'b00);
    cycle(1'b1, 1'b1, 1'b1, 2, 1, 1'b1, 6, 0, 2'b01);
    idle(3);

    // Zero latency behaves as ALU latency.
    cycle(1'b1, 1'b1, 1'b1, 11, 0, 1'b0, 0, 0, 2'b00);
    cycle(1'b1, 1'b0, 1'b0, 0, 1, 1'b0, 0, 11, 2'b10);
    idle(3);

    // Many two-cycle stalls to saturate the narrow counter.
    for (int k = 0; k < 10; k++) begin
      cycle(1'b1, 1'b1, 1'b1, 13, 3, 1'b0, 0, 0, 2'b00);
      repeat (3) cycle(1'b1, 1'b1, 1'b0, 1, 1, 1'b0, 13, 13, 2'b11);
    end
    idle(2);

    // Reset mid-stall, then capture on the first edge after release.
    cycle(1'b1, 1'b1, 1'b1, 12, 3, 1'b0, 0, 0, 2'b00);
    cycle(1'b1, 1'b1, 1'b1, 14, 1, 1'b0, 12, 0, 2'b01);
    cycle(1'b0, 1'b1, 1'b1, 14, 1, 1'b0, 12, 0, 2'b01);
    cycle(1'b1, 1'b1, 1'b1, 14, 1, 1'b0, 12, 0, 2'b01);
    cycle(1'b1, 1'b0, 1'b0, 0, 1, 1'b0, 14, 12, 2'b11);
    idle(3);

    // Randomized traffic; a stalled decode instruction is re-offered.
    iv = 0; iwe = 0; ird = 0; ilat = 1; s0 = 0; s1 = 0; used = 0;
    for (int n = 0; n < 1500; n++) begin
      rn = ($urandom_range(0, 199) != 0);
      if (!last_stall) begin
        iv   = ($urandom_range(0, 3) != 0);
        iwe  = ($urandom_range(0, 4) != 0);
        ird  = $urandom_range(0, 7);
        ilat = $urandom_range(0, 3);
        s0   = $urandom_range(0, 7);
        s1   = $urandom_range(0, 7);
        used = 2'($urandom_range(0, 3));
      end
      fl = ($urandom_range(0, 7) == 0);
      cycle(rn, iv, iwe, ird, ilat, fl, s0, s1, used);
    end

    repeat (3) @(negedge clk);
    #1;
    check("drain", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
